// File: rtl/transfer_parser_pkg.sv
// Shared constants and types for the transfer byte-stream parser.
// Ledger op/kind encodings and the emitter state enum live here.
package transfer_pkg;

  localparam logic       KIND_DEBIT  = 1'b0;
  localparam logic       KIND_CREDIT = 1'b1;
  localparam logic [1:0] OP_IDLE     = 2'd0;
  localparam logic [1:0] OP_TRANSFER = 2'd2;

  typedef enum logic [1:0] {
    EMIT_IDLE,
    EMIT_DEBIT,
    EMIT_CREDIT
  } emit_state_t;

  function automatic int pkt_bytes(input int key_bytes, input int val_bytes);
    return 2 * key_bytes + val_bytes;
  endfunction

endpackage

// File: rtl/transfer_parser_if.sv
// Byte-link input and ledger-transaction output of the transfer parser.
// The slave modport is the parser; the master modport is whoever drives it.
interface transfer_parser_if #(
  parameter int KEY_BYTES = 4,
  parameter int VAL_BYTES = 4
);

  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_sop;
  logic                   byte_ready;
  logic                   txn_valid;
  logic                   txn_ready;
  logic [1:0]             signal;
  logic [8*KEY_BYTES-1:0] key;
  logic                   transact_kind;
  logic [8*VAL_BYTES-1:0] transact_value;
  logic                   frame_err;
  logic [7:0]             err_count;

  modport master (
    output byte_in, byte_valid, byte_sop, txn_ready,
    input  byte_ready, txn_valid, signal, key, transact_kind,
           transact_value, frame_err, err_count
  );

  modport slave (
    input  byte_in, byte_valid, byte_sop, txn_ready,
    output byte_ready, txn_valid, signal, key, transact_kind,
           transact_value, frame_err, err_count
  );

endinterface

// File: rtl/transfer_fifo.sv
// Synchronous packet FIFO with registered full/empty flags.
// Pointers carry an extra wrap bit; head and the entry behind it are both visible.
module transfer_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           rd_data_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_d, rd_ptr_d;
  logic [AW-1:0]    rd_idx_next;
  logic             do_wr, do_rd;
  logic [WIDTH-1:0] mem [DEPTH];

  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign wr_ptr_d    = do_wr ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_d    = do_rd ? rd_ptr + 1'b1 : rd_ptr;
  assign rd_idx_next = rd_ptr[AW-1:0] + 1'b1;

  assign rd_data      = mem[rd_ptr[AW-1:0]];
  assign rd_data_next = mem[rd_idx_next];
  assign level        = wr_ptr - rd_ptr;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      full   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty  <= (wr_ptr_d == rd_ptr_d);
    end
  end

  // NOTE: storage has no reset; empty/full guard every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/transfer_parser.sv
// Transfer packet parser: assembles framed big-endian packets from the byte link,
// queues them, and emits each as a debit on the sender then a credit on the receiver.
module transfer_parser
  import transfer_pkg::*;
#(
  parameter int KEY_BYTES = 4,
  parameter int VAL_BYTES = 4,
  parameter int DEPTH     = 4
) (
  input  logic              tick_in,
  input  logic              rst_n,
  transfer_parser_if.slave  bus
);

  localparam int PKT_BYTES = pkt_bytes(KEY_BYTES, VAL_BYTES);
  localparam int KEY_BITS  = 8 * KEY_BYTES;
  localparam int VAL_BITS  = 8 * VAL_BYTES;
  localparam int PKT_BITS  = 8 * PKT_BYTES;
  localparam int IDX_W     = $clog2(PKT_BYTES);
  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  function automatic logic [KEY_BITS-1:0] sender_of(input logic [PKT_BITS-1:0] w);
    return w[PKT_BITS-1 -: KEY_BITS];
  endfunction

  function automatic logic [KEY_BITS-1:0] receiver_of(input logic [PKT_BITS-1:0] w);
    return w[VAL_BITS +: KEY_BITS];
  endfunction

  function automatic logic [VAL_BITS-1:0] value_of(input logic [PKT_BITS-1:0] w);
    return w[VAL_BITS-1:0];
  endfunction

  // ---------------- assembler and framing ----------------
  logic [IDX_W-1:0]    idx;
  logic [PKT_BITS-9:0] shift_q;
  logic [PKT_BITS-1:0] pkt_word;
  logic                accept, at_start, at_last;
  logic                sop_err, stray_err, pkt_done;
  logic                frame_err_q;
  logic [7:0]          err_count_q;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [PKT_BITS-1:0] fifo_head, fifo_next;
  logic [LVL_W-1:0]    fifo_level;

  assign at_start  = (idx == '0);
  assign at_last   = (idx == LAST_IDX);
  // Only the final byte needs a free slot; earlier bytes sit in the shift register.
  assign bus.byte_ready = !(at_last && fifo_full);
  assign accept    = bus.byte_valid && bus.byte_ready;
  assign sop_err   = accept && bus.byte_sop && !at_start;
  assign stray_err = accept && !bus.byte_sop && at_start;
  assign pkt_done  = accept && !bus.byte_sop && at_last;
  assign pkt_word  = {shift_q, bus.byte_in};

  always_ff @(posedge tick_in or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      frame_err_q <= sop_err || stray_err;
      if ((sop_err || stray_err) && err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
      if (accept) begin
        if (bus.byte_sop) begin
          idx     <= IDX_W'(1);
          shift_q <= pkt_word[PKT_BITS-9:0];
        end else if (!at_start) begin
          idx     <= at_last ? '0 : idx + 1'b1;
          shift_q <= pkt_word[PKT_BITS-9:0];
        end
      end
    end
  end

  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_count_q;

  transfer_fifo #(
    .WIDTH (PKT_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (tick_in),
    .rst_n        (rst_n),
    .wr_en        (pkt_done),
    .wr_data      (pkt_word),
    .rd_en        (fifo_pop),
    .rd_data      (fifo_head),
    .rd_data_next (fifo_next),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .level        (fifo_level)
  );

  // ---------------- emitter FSM ----------------
  emit_state_t         state_q, state_d;
  logic [PKT_BITS-1:0] pkt_q, pkt_d;
  logic                valid_q, valid_d;
  logic                kind_q, kind_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [VAL_BITS-1:0] value_q, value_d;
  logic [1:0]          signal_q, signal_d;

  always_ff @(posedge tick_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMIT_IDLE;
      pkt_q    <= '0;
      valid_q  <= 1'b0;
      kind_q   <= KIND_DEBIT;
      key_q    <= '0;
      value_q  <= '0;
      signal_q <= OP_IDLE;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      valid_q  <= valid_d;
      kind_q   <= kind_d;
      key_q    <= key_d;
      value_q  <= value_d;
      signal_q <= signal_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    valid_d  = valid_q;
    kind_d   = kind_q;
    key_d    = key_q;
    value_d  = value_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      EMIT_IDLE: begin
        if (!fifo_empty) begin
          pkt_d   = fifo_head;
          valid_d = 1'b1;
          kind_d  = KIND_DEBIT;
          key_d   = sender_of(fifo_head);
          value_d = value_of(fifo_head);
          state_d = EMIT_DEBIT;
        end
      end
      EMIT_DEBIT: begin
        if (bus.txn_ready) begin
          kind_d  = KIND_CREDIT;
          key_d   = receiver_of(pkt_q);
          state_d = EMIT_CREDIT;
        end
      end
      EMIT_CREDIT: begin
        if (bus.txn_ready) begin
          fifo_pop = 1'b1;
          // A second queued entry goes straight out as the next debit, no idle cycle.
          if (fifo_level > LVL_W'(1)) begin
            pkt_d   = fifo_next;
            kind_d  = KIND_DEBIT;
            key_d   = sender_of(fifo_next);
            value_d = value_of(fifo_next);
            state_d = EMIT_DEBIT;
          end else begin
            valid_d = 1'b0;
            state_d = EMIT_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = EMIT_IDLE;
      end
    endcase
    signal_d = valid_d ? OP_TRANSFER : OP_IDLE;
  end

  assign bus.txn_valid      = valid_q;
  assign bus.key            = key_q;
  assign bus.transact_kind  = kind_q;
  assign bus.transact_value = value_q;
  assign bus.signal         = signal_q;

endmodule

// File: tb/tb_transfer_parser.sv
// Directed bench for transfer_parser: latency, stall, back-pressure, framing,
// reset and a wide-value configuration, with hand-computed expectations.
module tb_transfer_parser;
  import transfer_pkg::*;

  logic tick_in = 1'b0;
  logic rst_n   = 1'b0;
  always #5 tick_in = ~tick_in;

  transfer_parser_if #(.KEY_BYTES(4), .VAL_BYTES(4)) bus ();
  transfer_parser_if #(.KEY_BYTES(2), .VAL_BYTES(8)) bus_w ();

  transfer_parser #(.KEY_BYTES(4), .VAL_BYTES(4), .DEPTH(4)) dut (
    .tick_in (tick_in),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  transfer_parser #(.KEY_BYTES(2), .VAL_BYTES(8), .DEPTH(4)) dut_w (
    .tick_in (tick_in),
    .rst_n   (rst_n),
    .bus     (bus_w.slave)
  );

  typedef struct packed {
    logic [31:0] key;
    logic        kind;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tick_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sop);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bus.byte_sop   = sop;
    while (!bus.byte_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("send_timeout_ready", {63'd0, bus.byte_ready}, 64'd1);
    step();
    bus.byte_valid = 1'b0;
    bus.byte_sop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] s, input logic [31:0] r, input logic [31:0] v);
    logic [95:0] w;
    w = {s, r, v};
    for (int i = 0; i < 12; i++) send_byte(w[95-8*i -: 8], i == 0);
  endtask

  task automatic expect_pkt(input logic [31:0] s, input logic [31:0] r, input logic [31:0] v);
    exp_q.push_back('{key: s, kind: KIND_DEBIT,  value: v});
    exp_q.push_back('{key: r, kind: KIND_CREDIT, value: v});
  endtask

  // Accepts transactions with txn_ready=1 and compares them in order; also completes
  // a byte left pending on the link. Ends one cycle after the last expected handshake.
  task automatic drain(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    logic byte_pending;
    bus.txn_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      byte_pending = bus.byte_valid && bus.byte_ready;
      if (bus.txn_valid) begin
        e = exp_q.pop_front();
        check({tag, "_key"},    64'(bus.key),            64'(e.key));
        check({tag, "_kind"},   64'(bus.transact_kind),  64'(e.kind));
        check({tag, "_value"},  64'(bus.transact_value), 64'(e.value));
        check({tag, "_signal"}, 64'(bus.signal),         64'(OP_TRANSFER));
      end
      step();
      if (byte_pending) begin
        bus.byte_valid = 1'b0;
        bus.byte_sop   = 1'b0;
      end
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_missing_txns"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check({tag, "_idle_after"}, 64'(bus.txn_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] w;
    logic        seen;

    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.byte_sop = 1'b0; bus.txn_ready = 1'b0;
    bus_w.byte_in = '0; bus_w.byte_valid = 1'b0; bus_w.byte_sop = 1'b0; bus_w.txn_ready = 1'b1;
    repeat (3) @(posedge tick_in);
    #1;
    check("rst_txn_valid",  64'(bus.txn_valid),      64'd0);
    check("rst_signal",     64'(bus.signal),         64'd0);
    check("rst_key",        64'(bus.key),            64'd0);
    check("rst_kind",       64'(bus.transact_kind),  64'd0);
    check("rst_value",      64'(bus.transact_value), 64'd0);
    check("rst_frame_err",  64'(bus.frame_err),      64'd0);
    check("rst_err_count",  64'(bus.err_count),      64'd0);
    check("rst_byte_ready", 64'(bus.byte_ready),     64'd1);
    rst_n = 1'b1;
    step();

    // Single packet, txn_ready high: debit at E1, credit at E2, idle at E3.
    bus.txn_ready = 1'b1;
    send_pkt(32'h0000_000A, 32'h0000_000B, 32'h0000_01F4);
    check("p1_latency_valid", 64'(bus.txn_valid), 64'd0);
    step();
    check("p1_debit_valid",  64'(bus.txn_valid),      64'd1);
    check("p1_debit_key",    64'(bus.key),            64'd10);
    check("p1_debit_kind",   64'(bus.transact_kind),  64'd0);
    check("p1_debit_value",  64'(bus.transact_value), 64'd500);
    check("p1_debit_signal", 64'(bus.signal),         64'd2);
    step();
    check("p1_credit_valid", 64'(bus.txn_valid),      64'd1);
    check("p1_credit_key",   64'(bus.key),            64'd11);
    check("p1_credit_kind",  64'(bus.transact_kind),  64'd1);
    check("p1_credit_value", 64'(bus.transact_value), 64'd500);
    step();
    check("p1_idle_valid",   64'(bus.txn_valid),      64'd0);
    check("p1_idle_signal",  64'(bus.signal),         64'd0);

    // Same packet with txn_ready low: debit must hold for five cycles.
    bus.txn_ready = 1'b0;
    send_pkt(32'h0000_000A, 32'h0000_000B, 32'h0000_01F4);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.txn_valid),      64'd1);
      check("stall_key",   64'(bus.key),            64'd10);
      check("stall_kind",  64'(bus.transact_kind),  64'd0);
      check("stall_value", 64'(bus.transact_value), 64'd500);
      step();
    end
    expect_pkt(32'h0000_000A, 32'h0000_000B, 32'h0000_01F4);
    drain("stall", 50);

    // DEPTH+1 packets with txn_ready low: the last byte of packet 5 must stall.
    bus.txn_ready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(32'h100 + p, 32'h200 + p, 32'h1000 + p);
    w = {32'h0000_0104, 32'h0000_0204, 32'h0000_1004};
    for (int i = 0; i < 11; i++) send_byte(w[95-8*i -: 8], i == 0);
    check("bp_ready_low", 64'(bus.byte_ready), 64'd0);
    bus.byte_in    = w[7:0];
    bus.byte_valid = 1'b1;
    bus.byte_sop   = 1'b0;
    step();
    step();
    check("bp_ready_held", 64'(bus.byte_ready), 64'd0);
    for (int p = 0; p < 5; p++) expect_pkt(32'h100 + p, 32'h200 + p, 32'h1000 + p);
    drain("bp", 100);

    // Framing: sop mid-packet discards the partial packet, then a stray byte.
    bus.txn_ready = 1'b1;
    w = {32'hDEAD_0001, 32'hBEEF_0002, 32'h0000_0077};
    for (int i = 0; i < 5; i++) send_byte(w[95-8*i -: 8], i == 0);
    check("fr_no_err_yet", 64'(bus.frame_err), 64'd0);
    w = {32'h0000_0021, 32'h0000_0022, 32'h0000_0333};
    for (int i = 0; i < 12; i++) begin
      send_byte(w[95-8*i -: 8], i == 0);
      if (i == 0) begin
        check("fr_sop_pulse", 64'(bus.frame_err), 64'd1);
        check("fr_count_1",   64'(bus.err_count), 64'd1);
      end
      if (i == 1) check("fr_pulse_end", 64'(bus.frame_err), 64'd0);
    end
    expect_pkt(32'h0000_0021, 32'h0000_0022, 32'h0000_0333);
    drain("fr", 50);
    send_byte(8'h55, 1'b0);
    check("stray_pulse",   64'(bus.frame_err), 64'd1);
    check("stray_count_2", 64'(bus.err_count), 64'd2);
    send_byte(8'h66, 1'b0);
    check("stray2_pulse",  64'(bus.frame_err), 64'd1);
    check("stray_count_3", 64'(bus.err_count), 64'd3);
    step();
    check("stray_pulse_end", 64'(bus.frame_err), 64'd0);
    check("stray_no_txn",    64'(bus.txn_valid), 64'd0);
    send_pkt(32'h0000_0031, 32'h0000_0032, 32'h0000_0444);
    expect_pkt(32'h0000_0031, 32'h0000_0032, 32'h0000_0444);
    drain("post_stray", 50);

    // Reset while in DEBIT with two packets queued.
    bus.txn_ready = 1'b0;
    send_pkt(32'h0000_0041, 32'h0000_0042, 32'h0000_0555);
    send_pkt(32'h0000_0051, 32'h0000_0052, 32'h0000_0666);
    check("rst_pre_valid", 64'(bus.txn_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",     64'(bus.txn_valid),      64'd0);
    check("mid_rst_signal",    64'(bus.signal),         64'd0);
    check("mid_rst_key",       64'(bus.key),            64'd0);
    check("mid_rst_value",     64'(bus.transact_value), 64'd0);
    check("mid_rst_err_count", 64'(bus.err_count),      64'd0);
    step();
    rst_n = 1'b1;
    bus.txn_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= bus.txn_valid;
    end
    check("post_rst_no_txn", 64'(seen),           64'd0);
    check("post_rst_ready",  64'(bus.byte_ready), 64'd1);
    send_pkt(32'h0000_0061, 32'h0000_0062, 32'h0000_0777);
    expect_pkt(32'h0000_0061, 32'h0000_0062, 32'h0000_0777);
    drain("post_rst", 50);

    // Wide configuration: 16-bit keys, 64-bit value.
    w = {16'h1234, 16'hABCD, 64'h0102_0304_0506_0708};
    for (int i = 0; i < 12; i++) begin
      bus_w.byte_in    = w[95-8*i -: 8];
      bus_w.byte_valid = 1'b1;
      bus_w.byte_sop   = (i == 0);
      step();
    end
    bus_w.byte_valid = 1'b0;
    bus_w.byte_sop   = 1'b0;
    check("w_latency_valid", 64'(bus_w.txn_valid), 64'd0);
    step();
    check("w_debit_valid", 64'(bus_w.txn_valid),      64'd1);
    check("w_debit_key",   64'(bus_w.key),            64'h1234);
    check("w_debit_kind",  64'(bus_w.transact_kind),  64'd0);
    check("w_debit_value", bus_w.transact_value,      64'h0102_0304_0506_0708);
    step();
    check("w_credit_key",   64'(bus_w.key),           64'hABCD);
    check("w_credit_kind",  64'(bus_w.transact_kind), 64'd1);
    check("w_credit_value", bus_w.transact_value,     64'h0102_0304_0506_0708);
    step();
    check("w_idle_valid", 64'(bus_w.txn_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
